// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the cache miss paths, the arbiter and main memory.
// master: arbiter side; slave: caches plus memory controller side.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
);
    logic                  i_req_valid;
    logic                  i_req_ready;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic                  i_resp_valid;
    logic [DATA_WIDTH-1:0] i_resp_data;
    logic                  d_req_valid;
    logic                  d_req_ready;
    logic                  d_req_rw;
    logic [ADDR_WIDTH-1:0] d_req_addr;
    logic [DATA_WIDTH-1:0] d_req_wdata;
    logic                  d_resp_valid;
    logic [DATA_WIDTH-1:0] d_resp_data;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_rw;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_data;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;

    modport master (
        input  i_req_valid, i_req_addr,
        input  d_req_valid, d_req_rw, d_req_addr, d_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output i_req_ready, i_resp_valid, i_resp_data,
        output d_req_ready, d_resp_valid, d_resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
    );

    modport slave (
        output i_req_valid, i_req_addr,
        output d_req_valid, d_req_rw, d_req_addr, d_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  i_req_ready, i_resp_valid, i_resp_data,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache and D-cache.
// One transaction in flight; read refills are routed back to the owner.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int BEATS      = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus,
    output logic          busy,
    output logic          err_stray
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               last_d;
    logic               owner_d;
    logic [CNT_W-1:0]   beat_cnt;
    logic               grant_d;
    logic               i_acc;
    logic               d_acc;
    logic               accept;
    logic               mem_hs;
    logic               beat_in;
    logic               last_beat;

    // Tie goes to the port that did not win last time.
    always_comb begin
        grant_d = 1'b0;
        if (bus.d_req_valid && (!bus.i_req_valid || !last_d)) begin
            grant_d = 1'b1;
        end
    end

    assign i_acc     = (state == IDLE) && bus.i_req_valid && !grant_d;
    assign d_acc     = (state == IDLE) && bus.d_req_valid && grant_d;
    assign accept    = i_acc || d_acc;
    assign mem_hs    = (state == ISSUE) && bus.mem_req_ready;
    assign beat_in   = (state == WAIT) && bus.mem_resp_valid;
    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

    assign bus.i_req_ready = i_acc;
    assign bus.d_req_ready = d_acc;
    assign busy            = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_req_ready) begin
                    state_nxt = bus.mem_req_rw ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid && last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_d            <= 1'b1;
            owner_d           <= 1'b0;
            beat_cnt          <= '0;
            err_stray         <= 1'b0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_rw    <= 1'b0;
            bus.mem_req_addr  <= '0;
            bus.mem_req_data  <= '0;
            bus.i_resp_valid  <= 1'b0;
            bus.i_resp_data   <= '0;
            bus.d_resp_valid  <= 1'b0;
            bus.d_resp_data   <= '0;
        end else begin
            bus.i_resp_valid <= 1'b0;
            bus.d_resp_valid <= 1'b0;
            if (bus.mem_resp_valid && (state != WAIT)) begin
                err_stray <= 1'b1;
            end
            if (accept) begin
                owner_d           <= grant_d;
                last_d            <= grant_d;
                bus.mem_req_valid <= 1'b1;
                bus.mem_req_rw    <= grant_d & bus.d_req_rw;
                bus.mem_req_addr  <= grant_d ? bus.d_req_addr : bus.i_req_addr;
                bus.mem_req_data  <= grant_d ? bus.d_req_wdata : '0;
            end
            if (mem_hs) begin
                bus.mem_req_valid <= 1'b0;
                beat_cnt          <= '0;
            end
            // Refill beats go only to the owner; data holds between beats.
            if (beat_in) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                if (owner_d) begin
                    bus.d_resp_valid <= 1'b1;
                    bus.d_resp_data  <= bus.mem_resp_data;
                end else begin
                    bus.i_resp_valid <= 1'b1;
                    bus.i_resp_data  <= bus.mem_resp_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: request/memory agents, a transaction-level
// reference model pushing expected commands/beats, and an output monitor.
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int NB = 4;

    typedef enum {P_IDLE, P_ISSUE, P_WAIT} phase_t;
    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } dreq_t;
    typedef struct {
        logic          own;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;
    typedef struct {
        logic          own;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic err_stray;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .BEATS(NB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .busy(busy),
        .err_stray(err_stray)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    int ready_pct = 100;
    int resp_pct = 100;
    logic fixed_data = 1'b1;
    logic gap_en = 1'b0;
    logic wd_en = 1'b0;
    int stray_req = 0;
    int stray_done = 0;

    logic [AW-1:0] i_todo[$];
    dreq_t         d_todo[$];
    logic          i_pend = 1'b0;
    logic          d_pend = 1'b0;
    logic [AW-1:0] i_cur = '0;
    dreq_t         d_cur = '{1'b0, '0, '0};

    cmd_t   cmd_q[$];
    rsp_t   resp_q[$];
    phase_t m_phase = P_IDLE;
    logic   m_last = 1'b1;
    logic   m_own = 1'b0;
    logic   m_rw = 1'b0;
    int     m_beats = 0;
    logic   exp_err = 1'b0;
    int     last_acc_cyc = 0;

    int   acc_log[$];
    int   i_cnt = 0;
    int   d_cnt = 0;
    int   mrv_cnt = 0;
    int   i_start = 0;
    logic prev_irv = 1'b0;

    task automatic chkb(input string nm, input logic got, input logic exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", nm, got, exp);
    endtask

    task automatic chki(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic chkw(input string nm, input logic [DW-1:0] got,
                        input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // I-cache requester agent
    initial begin
        bus.i_req_valid = 1'b0;
        bus.i_req_addr = '0;
        forever begin
            @(negedge clk);
            if (reset || (bus.i_req_valid && bus.i_req_ready)) i_pend = 1'b0;
            @(posedge clk);
            #1;
            if (!reset && !i_pend && i_todo.size() > 0 &&
                (!gap_en || $urandom_range(0, 1) == 1)) begin
                i_cur = i_todo.pop_front();
                i_pend = 1'b1;
            end
            bus.i_req_valid = i_pend && !reset &&
                              !(wd_en && $urandom_range(0, 7) == 0);
            bus.i_req_addr = i_cur;
        end
    end

    // D-cache requester agent
    initial begin
        bus.d_req_valid = 1'b0;
        bus.d_req_rw = 1'b0;
        bus.d_req_addr = '0;
        bus.d_req_wdata = '0;
        forever begin
            @(negedge clk);
            if (reset || (bus.d_req_valid && bus.d_req_ready)) d_pend = 1'b0;
            @(posedge clk);
            #1;
            if (!reset && !d_pend && d_todo.size() > 0 &&
                (!gap_en || $urandom_range(0, 1) == 1)) begin
                d_cur = d_todo.pop_front();
                d_pend = 1'b1;
            end
            bus.d_req_valid = d_pend && !reset &&
                              !(wd_en && $urandom_range(0, 7) == 0);
            bus.d_req_rw = d_cur.rw;
            bus.d_req_addr = d_cur.addr;
            bus.d_req_wdata = d_cur.data;
        end
    end

    // Memory agent: random command acceptance, refill beats while a read is open
    initial begin
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_req_ready = int'($urandom_range(0, 99)) < ready_pct;
            bus.mem_resp_valid = 1'b0;
            if (!reset && m_phase == P_WAIT &&
                int'($urandom_range(0, 99)) < resp_pct) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data = fixed_data ? DW'(32'hA0 + m_beats) : rnd_data();
            end else if (!reset && m_phase == P_IDLE && stray_done != stray_req) begin
                stray_done++;
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data = rnd_data();
            end
        end
    end

    // Reference model: one transaction at a time, round-robin on ties
    always @(negedge clk) begin
        logic ei;
        logic ed;
        cmd_t c;
        if (reset) begin
            m_phase = P_IDLE;
            m_last = 1'b1;
            m_beats = 0;
            exp_err = 1'b0;
            cmd_q.delete();
            resp_q.delete();
            chkb("rst_i_ready", bus.i_req_ready, 1'b0);
            chkb("rst_d_ready", bus.d_req_ready, 1'b0);
            chkb("rst_busy", busy, 1'b0);
            chkb("rst_err", err_stray, 1'b0);
        end else begin
            ei = m_phase == P_IDLE && bus.i_req_valid &&
                 (!bus.d_req_valid || m_last);
            ed = m_phase == P_IDLE && bus.d_req_valid && !ei;
            chkb("i_ready", bus.i_req_ready, ei);
            chkb("d_ready", bus.d_req_ready, ed);
            chkb("busy", busy, m_phase != P_IDLE);
            chkb("err_stray", err_stray, exp_err);
            case (m_phase)
                P_IDLE: begin
                    if (bus.mem_resp_valid) exp_err = 1'b1;
                    if (ei || ed) begin
                        c.own = ed;
                        c.rw = ed && bus.d_req_rw;
                        c.addr = ed ? bus.d_req_addr : bus.i_req_addr;
                        c.data = ed ? bus.d_req_wdata : '0;
                        cmd_q.push_back(c);
                        m_own = c.own;
                        m_rw = c.rw;
                        m_last = c.own;
                        m_phase = P_ISSUE;
                        last_acc_cyc = cyc;
                    end
                end
                P_ISSUE: begin
                    if (bus.mem_resp_valid) exp_err = 1'b1;
                    if (bus.mem_req_ready) begin
                        m_phase = m_rw ? P_IDLE : P_WAIT;
                        m_beats = 0;
                    end
                end
                default: begin
                    if (bus.mem_resp_valid) begin
                        resp_q.push_back('{m_own, bus.mem_resp_data});
                        m_beats++;
                        if (m_beats == NB) m_phase = P_IDLE;
                    end
                end
            endcase
        end
    end

    // Monitor: pops expected commands and refill beats as the DUT presents them
    always @(negedge clk) begin
        cmd_t c;
        rsp_t r;
        if (reset) begin
            prev_irv = 1'b0;
            chkb("rst_i_resp_valid", bus.i_resp_valid, 1'b0);
            chkb("rst_d_resp_valid", bus.d_resp_valid, 1'b0);
            chkw("rst_i_resp_data", bus.i_resp_data, '0);
            chkw("rst_d_resp_data", bus.d_resp_data, '0);
            chkb("rst_mem_valid", bus.mem_req_valid, 1'b0);
            chkb("rst_mem_rw", bus.mem_req_rw, 1'b0);
            chki("rst_mem_addr", int'(bus.mem_req_addr), 0);
            chkw("rst_mem_data", bus.mem_req_data, '0);
        end else begin
            chkb("both_ready", bus.i_req_ready && bus.d_req_ready, 1'b0);
            if (bus.i_req_valid && bus.i_req_ready) acc_log.push_back(0);
            if (bus.d_req_valid && bus.d_req_ready) acc_log.push_back(1);
            if (bus.mem_req_valid) begin
                mrv_cnt++;
                if (cmd_q.size() == 0) begin
                    chki("cmd_unexpected", cmd_q.size(), 1);
                end else begin
                    c = cmd_q[0];
                    chkb("mem_rw", bus.mem_req_rw, c.rw);
                    chki("mem_addr", int'(bus.mem_req_addr), int'(c.addr));
                    if (c.rw) chkw("mem_data", bus.mem_req_data, c.data);
                    if (bus.mem_req_ready) void'(cmd_q.pop_front());
                end
            end
            chkb("resp_both", bus.i_resp_valid && bus.d_resp_valid, 1'b0);
            if (bus.i_resp_valid) i_cnt++;
            if (bus.d_resp_valid) d_cnt++;
            if (bus.i_resp_valid && !prev_irv) i_start = cyc;
            prev_irv = bus.i_resp_valid;
            if (bus.i_resp_valid || bus.d_resp_valid) begin
                if (resp_q.size() == 0) begin
                    chki("resp_unexpected", resp_q.size(), 1);
                end else begin
                    r = resp_q.pop_front();
                    chkb("resp_owner", bus.d_resp_valid, r.own);
                    chkw("resp_data",
                         bus.d_resp_valid ? bus.d_resp_data : bus.i_resp_data,
                         r.data);
                end
            end
        end
    end

    task automatic wait_idle(input int lim);
        int n = 0;
        while (!(i_todo.size() == 0 && d_todo.size() == 0 && !i_pend && !d_pend &&
                 m_phase == P_IDLE && resp_q.size() == 0) && n < lim) begin
            @(posedge clk);
            n++;
        end
        chkb("idle_timeout", n < lim, 1'b1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int si;
        int sd;
        int sm;
        int base;
        int n;
        dreq_t dr;

        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);

        // Single I read with immediate memory
        si = i_cnt;
        sd = d_cnt;
        i_todo.push_back(AW'(28'h0000010));
        wait_idle(200);
        chki("i_read_beats", i_cnt - si, NB);
        chki("i_read_d_beats", d_cnt - sd, 0);
        chki("i_read_latency", i_start - last_acc_cyc, 3);

        // D write with memory stalling three cycles
        ready_pct = 0;
        sd = d_cnt;
        sm = mrv_cnt;
        d_todo.push_back('{1'b1, AW'(28'h0000020), DW'(32'hDEADBEEF)});
        n = 0;
        while (m_phase != P_ISSUE && n < 100) begin
            @(posedge clk);
            n++;
        end
        chkb("d_write_accept", n < 100, 1'b1);
        repeat (3) @(posedge clk);
        ready_pct = 100;
        wait_idle(200);
        chki("d_write_hold", mrv_cnt - sm, 4);
        chki("d_write_no_resp", d_cnt - sd, 0);

        // Both requesters valid from reset: grants alternate
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        base = acc_log.size();
        for (int k = 0; k < 3; k++) begin
            i_todo.push_back(AW'(28'h100 + k));
            d_todo.push_back('{k[0], AW'(28'h200 + k), rnd_data()});
        end
        wait_idle(500);
        chki("alt_count", acc_log.size() - base, 6);
        for (int k = 0; k < 6; k++) begin
            if (base + k < acc_log.size())
                chki("alt_order", acc_log[base + k], k % 2);
        end

        // Reset in the middle of a refill
        i_todo.push_back(AW'(28'h0000030));
        n = 0;
        while (!(m_phase == P_WAIT && m_beats == 2) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chkb("reach_wait", n < 200, 1'b1);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        si = i_cnt;
        i_todo.push_back(AW'(28'h0000040));
        wait_idle(200);
        chki("post_rst_beats", i_cnt - si, NB);
        chki("post_rst_latency", i_start - last_acc_cyc, 3);

        // Randomized traffic with stalls, gaps and withdrawn requests
        fixed_data = 1'b0;
        gap_en = 1'b1;
        wd_en = 1'b1;
        ready_pct = 60;
        resp_pct = 70;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                i_todo.push_back(AW'($urandom));
            end else begin
                dr.rw = 1'($urandom_range(0, 1));
                dr.addr = AW'($urandom);
                dr.data = rnd_data();
                d_todo.push_back(dr);
            end
        end
        wait_idle(20000);

        // Stray memory beat while idle
        gap_en = 1'b0;
        wd_en = 1'b0;
        ready_pct = 100;
        resp_pct = 100;
        si = i_cnt;
        sd = d_cnt;
        stray_req++;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        chkb("err_set", err_stray, 1'b1);
        chki("stray_no_i", i_cnt - si, 0);
        chki("stray_no_d", d_cnt - sd, 0);
        i_todo.push_back(AW'(28'h0000050));
        wait_idle(200);
        @(negedge clk);
        #1;
        chkb("err_sticky", err_stray, 1'b1);

        chki("cmd_q_left", cmd_q.size(), 0);
        chki("resp_q_left", resp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
